// File: rtl/pipeline_pkg.sv
// Shared pipeline types: the NOP used for bubbles and the fetch entry
// handed from the fetch stage to decode.
package pipeline_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pcPlus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory read port: one request per cycle, data returns the
// following cycle.
interface fetch_stage_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input  imem_rdata);
    modport slave  (input  imem_req, input  imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries. The head is read straight from
// storage, so a word pushed this cycle is only visible from the next one.
module fetch_fifo
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_clear,
    input  fetch_entry_t  i_data,
    output fetch_entry_t  o_head,
    output logic [CW-1:0] o_count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_push && !i_clear) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (i_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_count = r_count;

    pushNotFull: assert property (@(posedge clk) disable iff (!rst_n)
        (i_push && !i_pop && !i_clear) |-> (r_count < CW'(DEPTH)));

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC generation, instruction memory requests, latency-absorbing
// FIFO and the registered Fetch/Decode boundary.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int               WIDTH      = XLEN,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter int               FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_stage_if.master    imem,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             PCSrcE,
    input  logic [WIDTH-1:0] PCTargetE,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PCD,
    output logic [WIDTH-1:0] PCPlus4D,
    output logic             ValidD
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [WIDTH-1:0] r_pcF;
    logic             r_reqQ;
    logic [WIDTH-1:0] r_pcQ;

    logic             w_pop;
    logic             w_push;
    logic             w_issue;
    logic [WIDTH-1:0] w_addr;
    logic [CW-1:0]    w_count;
    logic [CW:0]      w_occ;
    fetch_entry_t     w_head;
    fetch_entry_t     w_pushData;

    assign w_pop  = !StallD && !FlushD && !PCSrcE && (w_count != '0);
    assign w_push = r_reqQ && !PCSrcE;

    // Occupancy after this cycle counts the response still in flight, so a
    // full FIFO under stall always has room for the word already requested.
    assign w_occ   = {1'b0, w_count} + (CW+1)'(r_reqQ) - (CW+1)'(w_pop);
    assign w_issue = rst_n && (PCSrcE || (w_occ < (CW+1)'(FIFO_DEPTH)));
    assign w_addr  = PCSrcE ? PCTargetE : r_pcF;

    assign imem.imem_req  = w_issue;
    assign imem.imem_addr = w_addr;

    assign w_pushData.instr = imem.imem_rdata;
    assign w_pushData.pc    = r_pcQ;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (PCSrcE),
        .i_data  (w_pushData),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pcF  <= RESET_PC;
            r_reqQ <= 1'b0;
            r_pcQ  <= '0;
        end else begin
            r_reqQ <= w_issue;
            if (w_issue) begin
                r_pcQ <= w_addr;
                r_pcF <= w_addr + WIDTH'(4);
            end
        end
    end

    // A redirect squashes the boundary even under a decode stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ValidD   <= 1'b0;
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
        end else if (FlushD || PCSrcE) begin
            ValidD <= 1'b0;
            InstrD <= NOP_INSTR;
        end else if (StallD) begin
            ValidD <= ValidD;
        end else if (w_pop) begin
            ValidD   <= 1'b1;
            InstrD   <= w_head.instr;
            PCD      <= w_head.pc;
            PCPlus4D <= pcPlus4(w_head.pc);
        end else begin
            ValidD <= 1'b0;
            InstrD <= NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations plus a
// queue-based model checked every cycle.
module tb_fetch_stage;
    import pipeline_pkg::*;

    localparam int          WIDTH    = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int compared   = 0;
    int mismatched = 0;
    bit cmpOn      = 1'b0;

    fetch_stage_if #(.WIDTH(WIDTH)) bus ();

    fetch_stage #(
        .WIDTH      (WIDTH),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem      (bus),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    always #5 clk = ~clk;

    // Memory holds its own word index at every word address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a >> 2;
    endfunction

    always @(posedge clk) begin
        if (bus.imem_req) begin
            bus.imem_rdata <= memWord(bus.imem_addr);
        end
    end

    fetch_entry_t mFifo[$];
    bit           mInflight;
    logic [31:0]  mInflightPc;
    logic [31:0]  mPC;
    logic         mValid;
    logic [31:0]  mInstr;
    logic [31:0]  mPCD;
    logic [31:0]  mPC4;
    bit           modelReady = 1'b0;

    function automatic bit expPop();
        return !StallD && !FlushD && !PCSrcE && (mFifo.size() > 0);
    endfunction

    function automatic bit expReq();
        if (!rst_n) return 1'b0;
        return PCSrcE || ((int'(mFifo.size()) + int'(mInflight) - int'(expPop())) < DEPTH);
    endfunction

    function automatic logic [31:0] expAddr();
        return PCSrcE ? PCTargetE : mPC;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Model steps on the same edge as the DUT, from the pre-edge inputs.
    always @(posedge clk) begin
        bit           pop;
        bit           req;
        logic [31:0]  addr;
        fetch_entry_t e;
        if (!rst_n) begin
            mFifo.delete();
            mInflight = 1'b0;
            mPC       = RESET_PC;
            mValid    = 1'b0;
            mInstr    = NOP_INSTR;
            mPCD      = 32'h0;
            mPC4      = 32'h0;
            modelReady = 1'b1;
        end else begin
            pop  = expPop();
            req  = expReq();
            addr = expAddr();
            if (FlushD || PCSrcE) begin
                mValid = 1'b0;
                mInstr = NOP_INSTR;
            end else if (StallD) begin
                mValid = mValid;
            end else if (pop) begin
                mValid = 1'b1;
                mInstr = mFifo[0].instr;
                mPCD   = mFifo[0].pc;
                mPC4   = mFifo[0].pc + 32'd4;
            end else begin
                mValid = 1'b0;
                mInstr = NOP_INSTR;
            end
            if (PCSrcE) begin
                mFifo.delete();
            end else begin
                if (pop) void'(mFifo.pop_front());
                if (mInflight) begin
                    e.instr = memWord(mInflightPc);
                    e.pc    = mInflightPc;
                    mFifo.push_back(e);
                end
            end
            checkOutput("fifoBound", 32'(mFifo.size() <= DEPTH), 32'd1);
            mInflight   = req;
            mInflightPc = addr;
            if (req) mPC = addr + 32'd4;
        end
    end

    always @(negedge clk) begin
        if (modelReady && cmpOn) begin
            checkOutput("imem_req", 32'(bus.imem_req), 32'(expReq()));
            if (expReq()) checkOutput("imem_addr", bus.imem_addr, expAddr());
            checkOutput("ValidD", 32'(ValidD), 32'(mValid));
            checkOutput("InstrD", InstrD, mInstr);
            checkOutput("PCD", PCD, mPCD);
            checkOutput("PCPlus4D", PCPlus4D, mPC4);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit f, input bit p, input logic [31:0] t);
        rst_n     = r;
        StallD    = s;
        FlushD    = f;
        PCSrcE    = p;
        PCTargetE = t;
    endtask

    task automatic waitValid(input int maxCycles);
        for (int n = 0; n < maxCycles; n++) begin
            step();
            @(negedge clk);
            if (ValidD === 1'b1) return;
        end
        compared++;
        mismatched++;
        $display("[TB] FAIL waitValid: ValidD is %b after %0d cycles, expected 1", ValidD, maxCycles);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cmpOn = 1'b1;
        step();
        step();
        @(negedge clk);
        checkOutput("rstValidD", 32'(ValidD), 32'd0);
        checkOutput("rstInstrD", InstrD, 32'h0000_0013);
        checkOutput("rstReq", 32'(bus.imem_req), 32'd0);

        // Straight-line fetch from reset
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("firstReq", 32'(bus.imem_req), 32'd1);
        checkOutput("firstAddr", bus.imem_addr, 32'h0);
        waitValid(5);
        checkOutput("firstPCD", PCD, 32'h0);
        checkOutput("firstInstr", InstrD, 32'h0);
        checkOutput("firstPC4", PCPlus4D, 32'h4);
        for (int k = 1; k <= 4; k++) begin
            step();
            @(negedge clk);
            checkOutput("streamPCD", PCD, 32'(4 * k));
            checkOutput("streamInstr", InstrD, 32'(k));
        end

        // Five-cycle decode stall
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            @(negedge clk);
            checkOutput("stallPCD", PCD, 32'd20);
            checkOutput("stallValid", 32'(ValidD), 32'd1);
            checkOutput("stallReq", 32'(bus.imem_req), 32'd0);
        end
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("stallLastHold", PCD, 32'd20);
        for (int k = 1; k <= 3; k++) begin
            step();
            @(negedge clk);
            checkOutput("resumePCD", PCD, 32'(20 + 4 * k));
        end

        // Redirect with a filled FIFO
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
        @(negedge clk);
        checkOutput("redirReq", 32'(bus.imem_req), 32'd1);
        checkOutput("redirAddr", bus.imem_addr, 32'h100);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("redirBubble", 32'(ValidD), 32'd0);
        waitValid(5);
        checkOutput("redirPCD", PCD, 32'h100);
        checkOutput("redirInstr", InstrD, 32'h40);
        checkOutput("redirPC4", PCPlus4D, 32'h104);
        step();
        @(negedge clk);
        checkOutput("redirNext", PCD, 32'h104);
        checkOutput("redirNextInstr", InstrD, 32'h41);

        // Redirect during a stall
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
        @(negedge clk);
        checkOutput("stallRedirReq", 32'(bus.imem_req), 32'd1);
        checkOutput("stallRedirAddr", bus.imem_addr, 32'h200);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("stallRedirBubble", 32'(ValidD), 32'd0);
        waitValid(5);
        checkOutput("stallRedirPCD", PCD, 32'h200);
        checkOutput("stallRedirInstr", InstrD, 32'h80);

        // Single-cycle flush
        step();
        @(negedge clk);
        checkOutput("preFlushPCD", PCD, 32'h204);
        step();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("flushCyclePCD", PCD, 32'h208);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("flushBubble", 32'(ValidD), 32'd0);
        checkOutput("flushHoldPCD", PCD, 32'h208);
        step();
        @(negedge clk);
        checkOutput("postFlushPCD", PCD, 32'h20C);
        checkOutput("postFlushValid", 32'(ValidD), 32'd1);

        // Reset with a request in flight
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("midRstReq", 32'(bus.imem_req), 32'd0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("midRstValid", 32'(ValidD), 32'd0);
        checkOutput("midRstInstr", InstrD, 32'h0000_0013);
        checkOutput("midRstPCD", PCD, 32'h0);
        checkOutput("midRstPC4", PCPlus4D, 32'h0);
        checkOutput("midRstAddr", bus.imem_addr, 32'h0);
        waitValid(5);
        checkOutput("restartPCD", PCD, 32'h0);
        checkOutput("restartInstr", InstrD, 32'h0);
        step();
        @(negedge clk);
        checkOutput("restartNext", PCD, 32'h4);

        // Mixed stalls, flushes and redirects against the model
        for (int i = 0; i < 120; i++) begin
            step();
            applyStimulus(1'b1, ($urandom % 4) == 0, ($urandom % 8) == 0,
                          ($urandom % 16) == 0, {22'h0, 8'($urandom_range(0, 255)), 2'b00});
        end
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
